cp0_regfile: RTL and testbench

- Coprocessor-0 register file for the dual-issue MIPS core: the receiving end of the exception code and Status/Cause path.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Serves MFC0/MTC0, commits exceptions and ERET from the writeback stage, and drives the redirect PC/flush.
- Exports Status and Cause to the interrupt-detection logic, closing the loop.

---
 rtl/cp0_regfile_if.sv | 38 +++
 rtl/cp0_regfile.sv | 139 +++++++++++++
 tb/tb_cp0_regfile.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if: the bus between the pipeline (writeback/MFC0/MTC0) and the
// coprocessor-0 register file.
//   master : pipeline side. Drives the MTC0 write, the MFC0 read address, the
//            exception/ERET commit and hw_int. Receives the read data, the
//            Status/Cause/EPC exports and the flush/redirect outputs.
//   slave  : cp0_regfile side, with the opposite directions.
interface cp0_if;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        flush_o;
    logic [31:0] flush_pc_o;
    logic        timer_int_o;

    modport master (
        output hw_int, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
        output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
        input  cp0_rdata, status_o, cause_o, epc_o, flush_o, flush_pc_o, timer_int_o
    );

    modport slave (
        input  hw_int, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
        input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
        output cp0_rdata, status_o, cause_o, epc_o, flush_o, flush_pc_o, timer_int_o
    );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: coprocessor-0 register file of the dual-issue MIPS core.
// Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
// Ports:
//   clk     core clock
//   resetn  asynchronous, active-low reset
//   bus     cp0_if.slave: MTC0 write, MFC0 read (combinational), exception
//           and ERET commit, hw_int, Status/Cause/EPC exports, flush and
//           redirect PC (combinational), timer interrupt (Cause.TI).
module cp0_regfile #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic  clk,
    input  logic  resetn,
    cp0_if.slave  bus
);

    // Status bits writable by MTC0: IM[15:8], EXL[1], IE[0]
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] epc;
    logic        cause_bd;
    logic        cause_ti;
    logic [5:0]  cause_iphw;
    logic [1:0]  cause_ipsw;
    logic [4:0]  cause_exccode;
    logic        tick;
    logic [31:0] cause;

    // An MTC0 is dropped whenever an exception or ERET commits in the same cycle
    logic wr_ok;
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    assign wr_ok      = bus.cp0_we & ~bus.exc_valid & ~bus.eret;
    assign wr_count   = wr_ok && (bus.cp0_waddr == REG_COUNT);
    assign wr_compare = wr_ok && (bus.cp0_waddr == REG_COMPARE);
    assign wr_status  = wr_ok && (bus.cp0_waddr == REG_STATUS);
    assign wr_cause   = wr_ok && (bus.cp0_waddr == REG_CAUSE);
    assign wr_epc     = wr_ok && (bus.cp0_waddr == REG_EPC);

    // IP[15] carries the timer interrupt on top of hw_int[5]
    assign cause = {cause_bd, cause_ti, 14'd0,
                    cause_iphw[5] | cause_ti, cause_iphw[4:0],
                    cause_ipsw, 1'b0, cause_exccode, 2'b00};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            badvaddr      <= '0;
            count         <= '0;
            compare       <= '0;
            status        <= STATUS_RESET;
            epc           <= '0;
            cause_bd      <= 1'b0;
            cause_ti      <= 1'b0;
            cause_iphw    <= '0;
            cause_ipsw    <= '0;
            cause_exccode <= '0;
            tick          <= 1'b0;
        end else begin
            // Timer and interrupt sampling run independently of commits
            tick       <= ~tick;
            cause_iphw <= bus.hw_int;

            if (wr_count)
                count <= bus.cp0_wdata;
            else if (tick)
                count <= count + 32'd1;

            if (wr_compare)
                compare <= bus.cp0_wdata;

            if (wr_compare)
                cause_ti <= 1'b0;
            else if ((count == compare) && (compare != 32'd0))
                cause_ti <= 1'b1;

            if (bus.exc_valid) begin
                status[1]     <= 1'b1;
                cause_exccode <= bus.exc_code;
                // A nested exception must not lose the original return point
                if (!status[1]) begin
                    epc      <= bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
                    cause_bd <= bus.exc_bd;
                end
                if ((bus.exc_code == 5'd4) || (bus.exc_code == 5'd5))
                    badvaddr <= bus.exc_badvaddr;
            end else if (bus.eret) begin
                status[1] <= 1'b0;
            end else begin
                if (wr_status)
                    status <= (status & ~STATUS_WMASK) | (bus.cp0_wdata & STATUS_WMASK);
                if (wr_cause)
                    cause_ipsw <= bus.cp0_wdata[9:8];
                if (wr_epc)
                    epc <= bus.cp0_wdata;
            end
        end
    end

    // MFC0 sees pre-edge state; a same-cycle MTC0 is not forwarded
    always_comb begin
        bus.cp0_rdata = 32'd0;
        case (bus.cp0_raddr)
            REG_BADVADDR: bus.cp0_rdata = badvaddr;
            REG_COUNT:    bus.cp0_rdata = count;
            REG_COMPARE:  bus.cp0_rdata = compare;
            REG_STATUS:   bus.cp0_rdata = status;
            REG_CAUSE:    bus.cp0_rdata = cause;
            REG_EPC:      bus.cp0_rdata = epc;
            default:      bus.cp0_rdata = 32'd0;
        endcase
    end

    always_comb begin
        bus.flush_pc_o = 32'd0;
        if (bus.exc_valid)
            bus.flush_pc_o = EXC_VECTOR;
        else if (bus.eret)
            bus.flush_pc_o = epc;
    end

    assign bus.flush_o     = bus.exc_valid | bus.eret;
    assign bus.status_o    = status;
    assign bus.cause_o     = cause;
    assign bus.epc_o       = epc;
    assign bus.timer_int_o = cause_ti;

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    cp0_if bus ();

    cp0_regfile dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    // Reference phase of the Count prescaler: cleared by reset, toggles each edge
    logic m_tick;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_tick <= 1'b0;
        else         m_tick <= ~m_tick;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.hw_int       = '0;
        bus.cp0_we       = 1'b0;
        bus.cp0_waddr    = '0;
        bus.cp0_wdata    = '0;
        bus.cp0_raddr    = '0;
        bus.exc_valid    = 1'b0;
        bus.exc_code     = '0;
        bus.exc_pc       = '0;
        bus.exc_bd       = 1'b0;
        bus.exc_badvaddr = '0;
        bus.eret         = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = a;
        bus.cp0_wdata = d;
        step();
        bus.cp0_we    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        exp_q.push_back(32'h0040_0000);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        repeat (3) step();
        resetn = 1'b1;
        step();
        exp = exp_q.pop_front(); checks++;
        if (bus.status_o !== exp) begin errors++; $display("FAIL reset_status: got %h expected %h", bus.status_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.cause_o !== exp) begin errors++; $display("FAIL reset_cause: got %h expected %h", bus.cause_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.epc_o !== exp) begin errors++; $display("FAIL reset_epc: got %h expected %h", bus.epc_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.flush_o} !== exp) begin errors++; $display("FAIL reset_flush: got %b expected %h", bus.flush_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.timer_int_o} !== exp) begin errors++; $display("FAIL reset_ti: got %b expected %h", bus.timer_int_o, exp); end
    endtask

    task automatic test_mtc0_mask();
        // Write Status and read it in the same cycle: old value must appear
        bus.cp0_raddr = 5'd12;
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd12;
        bus.cp0_wdata = 32'hFFFF_FFFF;
        exp_q.push_back(32'h0040_0000);
        exp_q.push_back(32'h0040_FF03);
        exp_q.push_back(32'h0040_FF03);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (bus.cp0_rdata !== exp) begin errors++; $display("FAIL no_bypass: got %h expected %h", bus.cp0_rdata, exp); end
        step();
        bus.cp0_we = 1'b0;
        exp = exp_q.pop_front(); checks++;
        if (bus.cp0_rdata !== exp) begin errors++; $display("FAIL status_mask_read: got %h expected %h", bus.cp0_rdata, exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.status_o !== exp) begin errors++; $display("FAIL status_mask_out: got %h expected %h", bus.status_o, exp); end

        exp_q.push_back(32'h0040_0000);
        mtc0(5'd12, 32'h0000_0000);
        exp = exp_q.pop_front(); checks++;
        if (bus.status_o !== exp) begin errors++; $display("FAIL status_clear: got %h expected %h", bus.status_o, exp); end

        bus.cp0_raddr = 5'd13;
        exp_q.push_back(32'h0000_0300);
        exp_q.push_back(32'h0000_0300);
        mtc0(5'd13, 32'hFFFF_FFFF);
        exp = exp_q.pop_front(); checks++;
        if (bus.cause_o !== exp) begin errors++; $display("FAIL cause_mask_out: got %h expected %h", bus.cause_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.cp0_rdata !== exp) begin errors++; $display("FAIL cause_mask_read: got %h expected %h", bus.cp0_rdata, exp); end
        exp_q.push_back(32'h0);
        mtc0(5'd13, 32'h0);
        exp = exp_q.pop_front(); checks++;
        if (bus.cause_o !== exp) begin errors++; $display("FAIL cause_clear: got %h expected %h", bus.cause_o, exp); end

        // BadVAddr ignores MTC0
        bus.cp0_raddr = 5'd8;
        exp_q.push_back(32'h0);
        mtc0(5'd8, 32'hDEAD_BEEF);
        exp = exp_q.pop_front(); checks++;
        if (bus.cp0_rdata !== exp) begin errors++; $display("FAIL badvaddr_ro: got %h expected %h", bus.cp0_rdata, exp); end

        exp_q.push_back(32'h1234_5678);
        mtc0(5'd14, 32'h1234_5678);
        exp = exp_q.pop_front(); checks++;
        if (bus.epc_o !== exp) begin errors++; $display("FAIL epc_write: got %h expected %h", bus.epc_o, exp); end

        bus.cp0_raddr = 5'd5;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (bus.cp0_rdata !== exp) begin errors++; $display("FAIL unmapped_read: got %h expected %h", bus.cp0_rdata, exp); end
    endtask

    task automatic test_hw_int();
        bus.hw_int = 6'b101010;
        exp_q.push_back(32'h0000_A800);
        exp_q.push_back(32'h0);
        step();
        bus.hw_int = 6'b000000;
        exp = exp_q.pop_front(); checks++;
        if (bus.cause_o !== exp) begin errors++; $display("FAIL hw_int_sample: got %h expected %h", bus.cause_o, exp); end
        step();
        exp = exp_q.pop_front(); checks++;
        if (bus.cause_o !== exp) begin errors++; $display("FAIL hw_int_release: got %h expected %h", bus.cause_o, exp); end
    endtask

    task automatic test_timer();
        int n;
        bit found;
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'h0);
        // Increments land on edges where the prescaler was 1 before the edge
        exp_q.push_back(m_tick ? 32'd9 : 32'd10);
        bus.cp0_raddr = 5'd9;
        n = 0;
        found = 1'b0;
        while (!found && n < 30) begin
            step();
            n++;
            if (bus.cp0_rdata === 32'd5) found = 1'b1;
        end
        exp = exp_q.pop_front(); checks++;
        if (!found || n !== int'(exp)) begin errors++; $display("FAIL count_to_5: got %0d cycles (found=%0d) expected %0d", n, found, exp); end

        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.timer_int_o} !== exp) begin errors++; $display("FAIL ti_not_early: got %b expected %h", bus.timer_int_o, exp); end

        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        step();
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.timer_int_o} !== exp) begin errors++; $display("FAIL ti_set: got %b expected %h", bus.timer_int_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.cause_o[30]} !== exp) begin errors++; $display("FAIL cause_ti: got %b expected %h", bus.cause_o[30], exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.cause_o[15]} !== exp) begin errors++; $display("FAIL cause_ip7: got %b expected %h", bus.cause_o[15], exp); end

        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        mtc0(5'd11, 32'd100);
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.timer_int_o} !== exp) begin errors++; $display("FAIL ti_clear: got %b expected %h", bus.timer_int_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.cause_o[15]} !== exp) begin errors++; $display("FAIL ip7_clear: got %b expected %h", bus.cause_o[15], exp); end

        // Count writes override the increment in either prescaler phase
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(32'h10 + 32'(k));
            mtc0(5'd9, 32'h10 + 32'(k));
            exp = exp_q.pop_front(); checks++;
            if (bus.cp0_rdata !== exp) begin errors++; $display("FAIL count_override%0d: got %h expected %h", k, bus.cp0_rdata, exp); end
        end

        mtc0(5'd11, 32'd0);
        exp_q.push_back(32'h0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        step();
        step();
        exp = exp_q.pop_front(); checks++;
        if (bus.cp0_rdata !== exp) begin errors++; $display("FAIL count_wrap: got %h expected %h", bus.cp0_rdata, exp); end
    endtask

    task automatic test_exception();
        bus.exc_valid    = 1'b1;
        bus.exc_code     = 5'd4;
        bus.exc_pc       = 32'h8000_0104;
        bus.exc_bd       = 1'b1;
        bus.exc_badvaddr = 32'h0000_0003;
        bus.cp0_raddr    = 5'd8;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'hBFC0_0380);
        #1;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.flush_o} !== exp) begin errors++; $display("FAIL exc_flush: got %b expected %h", bus.flush_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.flush_pc_o !== exp) begin errors++; $display("FAIL exc_vector: got %h expected %h", bus.flush_pc_o, exp); end
        exp_q.push_back(32'h8000_0100);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'h3);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        step();
        bus.exc_valid = 1'b0;
        #1;
        exp = exp_q.pop_front(); checks++;
        if (bus.epc_o !== exp) begin errors++; $display("FAIL exc_epc: got %h expected %h", bus.epc_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.cause_o[31]} !== exp) begin errors++; $display("FAIL exc_bd: got %b expected %h", bus.cause_o[31], exp); end
        exp = exp_q.pop_front(); checks++;
        if ({27'd0, bus.cause_o[6:2]} !== exp) begin errors++; $display("FAIL exc_code: got %0d expected %0d", bus.cause_o[6:2], exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.cp0_rdata !== exp) begin errors++; $display("FAIL exc_badvaddr: got %h expected %h", bus.cp0_rdata, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.status_o[1]} !== exp) begin errors++; $display("FAIL exc_exl: got %b expected %h", bus.status_o[1], exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.flush_o} !== exp) begin errors++; $display("FAIL exc_flush_drop: got %b expected %h", bus.flush_o, exp); end
    endtask

    task automatic test_nested();
        bus.exc_valid    = 1'b1;
        bus.exc_code     = 5'd8;
        bus.exc_pc       = 32'h8000_0200;
        bus.exc_bd       = 1'b0;
        bus.exc_badvaddr = 32'h0000_DEAD;
        exp_q.push_back(32'd8);
        exp_q.push_back(32'h8000_0100);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h3);
        step();
        bus.exc_valid = 1'b0;
        exp = exp_q.pop_front(); checks++;
        if ({27'd0, bus.cause_o[6:2]} !== exp) begin errors++; $display("FAIL nest_code: got %0d expected %0d", bus.cause_o[6:2], exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.epc_o !== exp) begin errors++; $display("FAIL nest_epc: got %h expected %h", bus.epc_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.cause_o[31]} !== exp) begin errors++; $display("FAIL nest_bd: got %b expected %h", bus.cause_o[31], exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.cp0_rdata !== exp) begin errors++; $display("FAIL nest_badvaddr: got %h expected %h", bus.cp0_rdata, exp); end
    endtask

    task automatic test_eret_collisions();
        bus.eret = 1'b1;
        exp_q.push_back(32'h8000_0100);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (bus.flush_pc_o !== exp) begin errors++; $display("FAIL eret_pc: got %h expected %h", bus.flush_pc_o, exp); end
        exp_q.push_back(32'h0);
        step();
        bus.eret = 1'b0;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.status_o[1]} !== exp) begin errors++; $display("FAIL eret_exl: got %b expected %h", bus.status_o[1], exp); end

        bus.eret      = 1'b1;
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd12;
        bus.cp0_wdata = 32'hFFFF_FFFF;
        exp_q.push_back(32'h0040_0000);
        step();
        bus.eret   = 1'b0;
        bus.cp0_we = 1'b0;
        exp = exp_q.pop_front(); checks++;
        if (bus.status_o !== exp) begin errors++; $display("FAIL eret_we_drop: got %h expected %h", bus.status_o, exp); end

        bus.exc_valid    = 1'b1;
        bus.eret         = 1'b1;
        bus.exc_code     = 5'd12;
        bus.exc_pc       = 32'h8000_0300;
        bus.exc_bd       = 1'b0;
        bus.exc_badvaddr = 32'h0000_0077;
        bus.cp0_we       = 1'b1;
        bus.cp0_waddr    = 5'd14;
        bus.cp0_wdata    = 32'h0000_5555;
        exp_q.push_back(32'hBFC0_0380);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (bus.flush_pc_o !== exp) begin errors++; $display("FAIL exc_eret_pc: got %h expected %h", bus.flush_pc_o, exp); end
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h8000_0300);
        exp_q.push_back(32'h3);
        exp_q.push_back(32'h0);
        step();
        idle_inputs();
        bus.cp0_raddr = 5'd8;
        #1;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, bus.status_o[1]} !== exp) begin errors++; $display("FAIL exc_eret_exl: got %b expected %h", bus.status_o[1], exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.epc_o !== exp) begin errors++; $display("FAIL exc_we_drop: got %h expected %h", bus.epc_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.cp0_rdata !== exp) begin errors++; $display("FAIL ov_badvaddr: got %h expected %h", bus.cp0_rdata, exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.flush_pc_o !== exp) begin errors++; $display("FAIL idle_flush_pc: got %h expected %h", bus.flush_pc_o, exp); end
    endtask

    task automatic test_async_reset();
        #2;
        resetn = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0040_0000);
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (bus.epc_o !== exp) begin errors++; $display("FAIL async_epc: got %h expected %h", bus.epc_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.status_o !== exp) begin errors++; $display("FAIL async_status: got %h expected %h", bus.status_o, exp); end
        exp = exp_q.pop_front(); checks++;
        if (bus.cause_o !== exp) begin errors++; $display("FAIL async_cause: got %h expected %h", bus.cause_o, exp); end
        step();
        resetn = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mtc0_mask();
        test_hw_int();
        test_timer();
        test_exception();
        test_nested();
        test_eret_collisions();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
